// File: rtl/load_scoreboard_pkg.sv
// Shared register-file constants for the load scoreboard and its tag FIFO.
package load_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/sb_tag_fifo.sv
// In-order FIFO of destination-register tags for outstanding long-latency ops.
module sb_tag_fifo
    import load_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  reg_addr_t               push_tag,
    input  logic                    pop,
    output reg_addr_t               head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    reg_addr_t        mem [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_tag;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/load_scoreboard.sv
// Decode-stage scoreboard for long-latency results: stalls RAW/WAW hazards on
// pending registers and names the writeback target of in-order completions.
// Optional macro SCOREBOARD_BYPASS_EN lets a dependent read proceed in the
// completion cycle of its producer.
module load_scoreboard
    import load_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  rd_write,
    input  logic                  cmpl_valid,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  busy,
    output logic                  full,
    output logic                  err_underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    reg_addr_t           head;
    logic [PTR_W:0]      count;
    logic                fifo_full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                bypass;

    function automatic logic hit(input reg_addr_t r, input logic [NUM_REGS-1:0] pend,
                                 input logic byp, input reg_addr_t head_tag);
        return (r != REG_ZERO) && pend[r] && !(byp && (head_tag == r));
    endfunction

    assign pop = cmpl_valid & ~empty;

`ifdef SCOREBOARD_BYPASS_EN
    assign bypass = pop;
`else
    assign bypass = 1'b0;
`endif

    assign stall = hit(rs1, pending, bypass, head)
                 | hit(rs2, pending, bypass, head)
                 | (rd_write & hit(rd, pending, bypass, head))
                 | (issue_valid & fifo_full);

    assign push     = issue_valid & ~stall;
    assign wb_valid = pop;
    assign wb_rd    = pop ? head : REG_ZERO;
    assign busy     = (count != '0);
    assign full     = fifo_full;

    sb_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_tag (issue_rd),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .full     (fifo_full),
        .empty    (empty)
    );

    // Set is applied after clear so a re-issue to the completing register wins.
    always_comb begin
        pending_next = pending;
        if (pop) pending_next[head] = 1'b0;
        if (push && (issue_rd != REG_ZERO)) pending_next[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending       <= '0;
            err_underflow <= 1'b0;
        end else begin
            pending <= pending_next;
            if (cmpl_valid && empty) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_scoreboard.sv
// Bench for load_scoreboard: directed vector table plus randomized traffic
// against a queue-based reference model.
module tb_load_scoreboard;

    localparam int DEPTH = 4;
`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_write;
    logic       cmpl_valid;
    logic       stall;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       busy;
    logic       full;
    logic       err_underflow;

    load_scoreboard #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .rd_write      (rd_write),
        .cmpl_valid    (cmpl_valid),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .busy          (busy),
        .full          (full),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       iv;
        logic [4:0] ird;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] rdd;
        logic       rdw;
        logic       cv;
        logic       chk;
        logic       e_stall;
        logic       e_wbv;
        logic [4:0] e_wbrd;
        logic       e_busy;
        logic       e_full;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic iv, input int ird,
                                input int r1, input int r2, input int rdd, input logic rdw,
                                input logic cv, input logic chk, input logic e_stall,
                                input logic e_wbv, input int e_wbrd, input logic e_busy,
                                input logic e_full, input logic e_err);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ird = ird[4:0]; v.r1 = r1[4:0]; v.r2 = r2[4:0];
        v.rdd = rdd[4:0]; v.rdw = rdw; v.cv = cv; v.chk = chk; v.e_stall = e_stall;
        v.e_wbv = e_wbv; v.e_wbrd = e_wbrd[4:0]; v.e_busy = e_busy; v.e_full = e_full;
        v.e_err = e_err;
        tbl.push_back(v);
    endfunction

    task automatic drive(input logic rst, input logic iv, input logic [4:0] ird,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                         input logic rdw, input logic cv);
        reset = rst; issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
        rd = rdd; rd_write = rdw; cmpl_valid = cv;
    endtask

    // Reference model: outstanding tags in order; a register is pending if it is queued.
    int q[$];
    bit merr;

    function automatic bit mhit(input int r, input bit mpop, input int head);
        bit found = 1'b0;
        foreach (q[k]) if (q[k] == r) found = 1'b1;
        return (r != 0) && found && !(BYP && mpop && (head == r));
    endfunction

    initial begin
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        //   rst iv ird r1 r2 rd rdw cv chk  stall wbv wbrd busy full err
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 1, 5, 0, 0, 5, 1, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 5, 0, 0, 0, 0, 1,   1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 5, 0, 0, 0, 1, 1,   !BYP, 1, 5, 1, 0, 0);
        add(0, 0, 0, 5, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        // fill to DEPTH, blocked issue, pop-and-issue while full
        add(0, 1, 1, 0, 0, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 0, 0, 2, 1, 0, 1,   0, 0, 0, 1, 0, 0);
        add(0, 1, 3, 0, 0, 3, 1, 0, 1,   0, 0, 0, 1, 0, 0);
        add(0, 1, 4, 0, 0, 4, 1, 0, 1,   0, 0, 0, 1, 0, 0);
        add(0, 1, 6, 0, 0, 6, 1, 0, 1,   1, 0, 0, 1, 1, 0);
        add(0, 1, 6, 0, 0, 6, 1, 1, 1,   1, 1, 1, 1, 1, 0);
        add(0, 1, 6, 0, 0, 6, 1, 0, 1,   0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 2, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 6, 1, 0, 0);
        // x0 tag is queued but never pending
        add(0, 1, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        // underflow is sticky; bypass case on x7
        add(0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1);
        add(0, 1, 7, 0, 0, 7, 1, 0, 1,   0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 7, 0, 0, 1, 1,   !BYP, 1, 7, 1, 0, 1);
        add(0, 0, 0, 0, 7, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1);
        // reset with three outstanding
        add(0, 1, 8, 0, 0, 8, 1, 0, 1,   0, 0, 0, 0, 0, 1);
        add(0, 1, 9, 0, 0, 9, 1, 0, 1,   0, 0, 0, 1, 0, 1);
        add(0, 1, 10, 0, 0, 10, 1, 0, 1, 0, 0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 9, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].iv, tbl[i].ird, tbl[i].r1, tbl[i].r2,
                  tbl[i].rdd, tbl[i].rdw, tbl[i].cv);
            #1;
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
                check($sformatf("vec%0d_wb_valid", i), wb_valid, tbl[i].e_wbv);
                check($sformatf("vec%0d_wb_rd", i), wb_rd, tbl[i].e_wbrd);
                check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
                check($sformatf("vec%0d_full", i), full, tbl[i].e_full);
                check($sformatf("vec%0d_err", i), err_underflow, tbl[i].e_err);
            end
        end

        // Randomized traffic; the issuing instruction's rd is its issue_rd.
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        q.delete();
        merr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic       r_rst, r_iv, r_rdw, r_cv;
            logic [4:0] r_ird, r_r1, r_r2, r_rd;
            int  sz, head;
            bit  mpop, mst;
            @(negedge clk);
            r_rst = ($urandom_range(0, 99) == 0);
            r_iv  = $urandom_range(0, 1);
            r_ird = 5'($urandom_range(0, 7));
            r_r1  = 5'($urandom_range(0, 7));
            r_r2  = 5'($urandom_range(0, 7));
            r_rdw = r_iv ? 1'b1 : 1'($urandom_range(0, 1));
            r_rd  = r_iv ? r_ird : 5'($urandom_range(0, 7));
            r_cv  = ($urandom_range(0, 99) < 35);
            drive(r_rst, r_iv, r_ird, r_r1, r_r2, r_rd, r_rdw, r_cv);
            #1;
            sz   = q.size();
            mpop = r_cv && (sz > 0);
            head = (sz > 0) ? q[0] : 0;
            mst  = mhit(int'(r_r1), mpop, head) || mhit(int'(r_r2), mpop, head)
                || (r_rdw && mhit(int'(r_rd), mpop, head)) || (r_iv && (sz == DEPTH));
            check("rnd_stall", stall, mst);
            check("rnd_wb_valid", wb_valid, mpop);
            check("rnd_wb_rd", wb_rd, mpop ? head : 0);
            check("rnd_busy", busy, sz > 0);
            check("rnd_full", full, sz == DEPTH);
            check("rnd_err", err_underflow, merr);
            if (r_rst) begin
                q.delete();
                merr = 1'b0;
            end else begin
                if (r_cv && (sz == 0)) merr = 1'b1;
                if (mpop) void'(q.pop_front());
                if (r_iv && !mst) q.push_back(int'(r_ird));
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Tracks destination registers of outstanding long-latency operations (data-memory loads, multi-cycle ALU ops) in the RV32I pipeline. It raises a decode-stage stall when an instruction reads or overwrites a register whose result has not yet returned. It also supplies the writeback destination when an in-order completion arrives. It is the producer-side counterpart of the forwarding logic: it decides when data cannot yet be forwarded and holds the pipeline until it can.

## Interface
- DEPTH, 4, max outstanding operations; power of two, ≥2
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  decode requests issue of a long-latency op this cycle
- issue_rd  in  5  destination register of that op
- rs1  in  5  decode source register 1
- rs2  in  5  decode source register 2
- rd  in  5  decode destination register (WAW check)
- rd_write  in  1  decode instruction writes rd
- cmpl_valid  in  1  oldest outstanding op returns its result this cycle
- stall  out  1  hold decode/fetch (combinational)
- wb_valid  out  1  completion accepted this cycle (combinational)
- wb_rd  out  5  destination of completing op = FIFO head (combinational)
- busy  out  1  ≥1 op outstanding (registered)
- full  out  1  DEPTH ops outstanding (registered)
- err_underflow  out  1  sticky: completion arrived with nothing outstanding

## Operation
- State: 32-bit pending vector; in-order tag FIFO of DEPTH × 5-bit entries; rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH; count of log2(DEPTH)+1 bits.
- hit(r) = (r != 0) & pending[r].
- stall = hit(rs1) | hit(rs2) | (rd_write & hit(rd)) | (issue_valid & full).
- push = issue_valid & ~stall: write issue_rd at wr pointer; set pending[issue_rd] unless issue_rd == 0. An x0 tag is still queued so that completion order stays aligned.
- pop = cmpl_valid & busy: wb_valid=1; wb_rd = head tag; clear pending[head]; advance rd pointer.
- cmpl_valid & ~busy: ignored, no state change, err_underflow set; it clears only on reset.
- Push and pop in the same cycle: count unchanged. If the set and clear target the same register, set wins.
- Push while full never happens, because stall suppresses it. Pop and issue in the same full cycle still stalls the issue.
- Pending bits are unique per register: WAW stall blocks a second issue to a pending rd.

## Timing
- Reset (synchronous): pending=0, pointers=0, count=0, err_underflow=0. On the next edge busy=0, full=0, wb_valid=0, wb_rd=0, and stall=0 for any inputs except issue_valid with full (full is 0).
- Reset asserted mid-operation discards all outstanding tags. Completions arriving afterwards flag underflow.
- stall, wb_valid and wb_rd are combinational from registered state plus the current inputs. No path from stall feeds back into its own inputs.
- A push in cycle N makes hit() true from cycle N+1.
- A pop in cycle N clears hit() from cycle N+1, unless bypass is compiled in.
- busy and full reflect the count after each edge.

## Configuration
- SCOREBOARD_BYPASS_EN defined: a hit on register r does not stall when cmpl_valid & busy & (wb_rd == r) in the same cycle. The forwarding path supplies the returning data, so the dependent instruction proceeds in the completion cycle.
- SCOREBOARD_BYPASS_EN undefined: the dependent instruction stalls through the completion cycle and proceeds one cycle later.

## Structure
- Shared package constants: REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0. Reuse the existing rv32i defines where present.
- One sub-module: sb_tag_fifo, a parameterised DEPTH×REG_ADDR_W in-order FIFO with push/pop, head, count, full and empty outputs. The pending vector, hazard compare and bypass logic stay in load_scoreboard.

## Test plan
- Reset, issue x5; next cycle rs1=5 → stall=1. Assert cmpl_valid → wb_valid=1, wb_rd=5. Following cycle → stall=0, busy=0.
- Issue x1, x2, x3, x4 on consecutive cycles (DEPTH=4) → full=1. Issue x6 → stall=1, no push. cmpl_valid → wb_rd=1, then full=0 and the x6 issue is accepted.
- Issue x0; then rs1=0, rs2=0 → stall=0, busy=1. cmpl_valid → wb_rd=0, busy=0.
- cmpl_valid while empty → err_underflow=1 and stays 1 after further traffic. wb_valid=0, pending unchanged.
- x7 at FIFO head, rs2=7, cmpl_valid in the same cycle → stall=0 with SCOREBOARD_BYPASS_EN, stall=1 without it.
- Three ops outstanding (x8, x9, x10), reset for one cycle → busy=0, full=0, and rs1=9 → stall=0.
